// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the execute stage and a word-organised data RAM.
// It formats RV32 byte/half/word accesses and flags misaligned, illegal and timed-out requests.
module lsu_mem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_data_o,
    output logic              resp_err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wr_mask_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ready_i
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_ERR} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;

    logic        req_illegal;
    logic        req_misaligned;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_fmt;
    logic [31:0] store_wdata;
    logic [3:0]  store_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Request checks are evaluated on the raw inputs so the error path costs one cycle.
    always_comb begin
        req_illegal = 1'b0;
        case (req_op_i[2:0])
            3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
            3'b100, 3'b101:         req_illegal = req_op_i[3];
            default:                req_illegal = 1'b0;
        endcase
        req_misaligned = 1'b0;
        case (req_op_i[1:0])
            2'b01:   req_misaligned = req_addr_i[0];
            2'b10:   req_misaligned = (req_addr_i[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        rd_byte  = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        rd_half  = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        load_fmt = mem_rdata_i;
        case (op_q[2:0])
            3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_fmt = {24'b0, rd_byte};
            3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_fmt = {16'b0, rd_half};
            default: load_fmt = mem_rdata_i;
        endcase
    end

    always_comb begin
        store_wdata = wdata_q;
        store_mask  = 4'b1111;
        case (op_q[1:0])
            2'b00: begin
                store_wdata = {4{wdata_q[7:0]}};
                store_mask  = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                store_wdata = {2{wdata_q[15:0]}};
                store_mask  = 4'b0011 << addr_q[1:0];
            end
            default: begin
                store_wdata = wdata_q;
                store_mask  = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = '0;
                    if (req_illegal || req_misaligned) begin
                        state_d = S_ERR;
                        rdata_d = '0;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // A ready arriving on the last allowed cycle still completes the access.
                if (mem_ready_i) begin
                    rdata_d = op_q[3] ? 32'b0 : load_fmt;
                    state_d = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o   = (state_q == S_IDLE);
        resp_valid_o  = (state_q == S_RESP) || (state_q == S_ERR);
        resp_err_o    = (state_q == S_ERR);
        resp_data_o   = rdata_q;
        mem_en_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_wr_mask_o = '0;
        if (state_q == S_ACCESS) begin
            mem_en_o   = 1'b1;
            mem_we_o   = op_q[3];
            mem_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
            if (op_q[3]) begin
                mem_wdata_o   = store_wdata;
                mem_wr_mask_o = store_mask;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl: a byte-level RAM model and RV32 access rules
// predict every response, latency and memory-port value.
module tb_lsu_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_op_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wr_mask_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    int checks   = 0;
    int failures = 0;
    logic [31:0] mem_model [int];

    lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wr_mask_o(mem_wr_mask_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int wa);
        if (mem_model.exists(wa)) return mem_model[wa];
        return (32'(wa) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
    endfunction

    function automatic int op_size(input logic [3:0] op);
        case (op[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit op_bad(input logic [3:0] op, input logic [31:0] a);
        int  f = int'(op[2:0]);
        bit  legal = op[3] ? (f <= 2) : (f <= 2 || f == 4 || f == 5);
        if (!legal) return 1'b1;
        return (int'(a[1:0]) % op_size(op)) != 0;
    endfunction

    function automatic logic [31:0] load_value(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] word);
        logic [31:0] lane = word >> (8 * int'(a[1:0]));
        case (op[2:0])
            3'b000:  return 32'($signed(lane[7:0]));
            3'b100:  return {24'b0, lane[7:0]};
            3'b001:  return 32'($signed(lane[15:0]));
            3'b101:  return {16'b0, lane[15:0]};
            default: return word;
        endcase
    endfunction

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        check_eq({tag, "_rvalid"}, 32'(resp_valid_o), 32'd0);
        check_eq({tag, "_rerr"}, 32'(resp_err_o), 32'd0);
        check_eq({tag, "_rdata"}, resp_data_o, 32'd0);
        check_eq({tag, "_mem_ctl"}, {29'b0, mem_en_o, mem_we_o, 1'b0}, 32'd0);
        check_eq({tag, "_mem_addr"}, mem_addr_o, 32'd0);
        check_eq({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
        check_eq({tag, "_mem_mask"}, 32'(mem_wr_mask_o), 32'd0);
    endtask

    task automatic run_txn(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input int waits, input bit noise);
        int          wa      = int'(addr >> 2);
        int          sz      = op_size(op);
        int          off     = int'(addr[1:0]);
        bit          bad     = op_bad(op, addr);
        bit          tmo     = !bad && (waits >= TO);
        int          exp_lat = bad ? 1 : (tmo ? TO + 1 : waits + 2);
        int          exp_acc = bad ? 0 : (tmo ? TO : waits + 1);
        logic [3:0]  exp_mask = 4'(((1 << sz) - 1) << off);
        logic [31:0] exp_wd;
        logic [31:0] exp_data;
        logic [31:0] w;
        int          cyc = 0;
        int          acc = 0;
        bit          done = 1'b0;

        exp_wd = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
        exp_data = (bad || tmo || op[3]) ? 32'd0 : load_value(op, addr, mem_rd(wa));

        @(negedge clk);
        check_eq("req_ready_idle", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_addr_i  = addr;
        req_wdata_i = wd;
        @(negedge clk);
        cyc = 1;
        if (noise) begin
            req_op_i    = 4'($urandom);
            req_addr_i  = $urandom;
            req_wdata_i = $urandom;
        end else begin
            req_valid_i = 1'b0;
        end
        while (!done && cyc < 100) begin
            mem_ready_i = 1'b0;
            mem_rdata_i = $urandom;
            if (resp_valid_o) begin
                done = 1'b1;
            end else begin
                check_eq("busy_not_ready", 32'(req_ready_o), 32'd0);
                if (mem_en_o) begin
                    check_eq("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
                    check_eq("mem_we", 32'(mem_we_o), 32'(op[3]));
                    check_eq("mem_mask", 32'(mem_wr_mask_o), op[3] ? 32'(exp_mask) : 32'd0);
                    if (op[3]) check_eq("mem_wdata", mem_wdata_o, exp_wd);
                    if (acc == waits) begin
                        mem_ready_i = 1'b1;
                        mem_rdata_i = mem_rd(wa);
                    end
                    acc++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        req_valid_i = 1'b0;
        mem_ready_i = 1'b0;
        if (!done) begin
            check_eq("resp_bound", 32'd0, 32'd1);
        end else begin
            check_eq("resp_latency", 32'(cyc), 32'(exp_lat));
            check_eq("access_cycles", 32'(acc), 32'(exp_acc));
            check_eq("resp_err", 32'(resp_err_o), 32'(bad || tmo));
            check_eq("resp_data", resp_data_o, exp_data);
        end
        @(negedge clk);
        check_eq("post_rvalid", 32'(resp_valid_o), 32'd0);
        check_eq("post_ready", 32'(req_ready_o), 32'd1);
        check_eq("resp_hold", resp_data_o, exp_data);
        if (op[3] && !bad && !tmo) begin
            w = mem_rd(wa);
            for (int i = 0; i < 4; i++)
                if (exp_mask[i]) w[8*i +: 8] = exp_wd[8*i +: 8];
            mem_model[wa] = w;
        end
        $display("TXN op=%h addr=%08h wdata=%08h waits=%0d noise=%0d exp_err=%0d exp_data=%08h got_err=%0d got_data=%08h lat=%0d",
                 op, addr, wd, waits, noise, bad || tmo, exp_data, resp_err_o, resp_data_o, cyc);
    endtask

    initial begin
        logic [3:0]  op_tab [12];
        logic [31:0] a;
        logic [3:0]  op;

        op_tab = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'h3, 4'hC, 4'hE, 4'h6};
        reset       = 1'b1;
        req_valid_i = 1'b0;
        req_op_i    = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        mem_rdata_i = '0;
        mem_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_init");
        reset = 1'b0;

        run_txn(4'hA, 32'h100, 32'hDEADBEEF, 0, 1'b0);
        run_txn(4'h2, 32'h100, 32'h0, 1, 1'b0);
        run_txn(4'h8, 32'h203, 32'h123456A5, 0, 1'b0);
        mem_model[32'h300 >> 2] = 32'h80F17F01;
        run_txn(4'h1, 32'h302, 32'h0, 2, 1'b0);
        run_txn(4'h5, 32'h302, 32'h0, 2, 1'b0);
        run_txn(4'h0, 32'h301, 32'h0, 0, 1'b0);
        run_txn(4'h2, 32'h102, 32'h0, 0, 1'b0);
        run_txn(4'hC, 32'h100, 32'h0, 0, 1'b0);
        run_txn(4'h2, 32'h40, 32'h0, 20, 1'b0);
        run_txn(4'h2, 32'h44, 32'h0, TO - 1, 1'b0);

        // Abort a load in ACCESS with an asynchronous reset pulse.
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i    = 4'h2;
        req_addr_i  = 32'h80;
        @(negedge clk);
        req_valid_i = 1'b0;
        check_eq("abort_in_access", 32'(mem_en_o), 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_async");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("no_resp_after_abort", 32'(resp_valid_o), 32'd0);
        end
        run_txn(4'h2, 32'h80, 32'h0, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            op = op_tab[$urandom_range(0, 11)];
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            run_txn(op, a, $urandom, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
